lifo_buffer: RTL
================

# lifo_buffer

Parametrised LIFO (stack) buffer with configurable word width and depth. It provides exact entry count, full/empty and programmable almost-full/almost-empty flags, a registered pop output with a valid strobe, combinational top-of-stack peek, and sticky overflow/underflow error flags. A simultaneous push and pop replaces the top entry in one cycle. It is the general-purpose stack primitive for datapath and parser blocks in the design.

## Interface
- WORD_BITS, 8, data word width
- ADRS_BITS, 3, address width; DEPTH = 2**ADRS_BITS entries
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear of contents and error flags
- push  in  1  push request
- push_data  in  WORD_BITS  word to push
- pop  in  1  pop request
- pop_data  out  WORD_BITS  registered popped word
- pop_valid  out  1  pop_data updated this cycle (one-cycle strobe)
- top_data  out  WORD_BITS  current top entry (combinational), 0 when empty
- count  out  ADRS_BITS+1  number of stored entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was made on an empty buffer

## Operation
- Storage: DEPTH x WORD_BITS register array, not reset. Only count, pop_data, pop_valid and the sticky flags are reset.
- count is the write index. The top entry is at mem[count-1]. count is ADRS_BITS+1 wide, so full and empty are unambiguous.
- Per-cycle priority is rst > clr > push/pop.
- Push only, not full:
  - mem[count] <= push_data
  - count+1
- Push only, full: word dropped, count unchanged, overflow <= 1.
- Pop only, not empty:
  - pop_data <= mem[count-1]
  - pop_valid <= 1
  - count-1
- Pop only, empty: underflow <= 1, pop_valid <= 0, pop_data holds its value.
- Push and pop, not empty (including full): replace top.
  - pop_data <= old mem[count-1], pop_valid <= 1
  - mem[count-1] <= push_data
  - count unchanged, no overflow
- Push and pop, empty: bypass.
  - pop_data <= push_data, pop_valid <= 1
  - count stays 0, no underflow
- Neither: pop_valid <= 0, all else holds.
- clr: count <= 0, pop_valid <= 0, overflow <= 0, underflow <= 0. pop_data holds. push/pop in the same cycle are ignored.
- overflow and underflow stay set until clr or rst.
- Status flags are pure decodes of the count register.

## Timing
- Reset values: count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full = (AF_LEVEL==0), top_data=0.
- Pop latency: pop_data/pop_valid are valid the cycle after the pop is sampled.
- count and flags update the cycle after the operation. A push into the last slot gives full=1 on the next cycle.
- top_data reflects a pushed word the cycle after the push, with no extra latency.
- Back-to-back push or pop every cycle is supported at full rate. No request is ever stalled; requests the buffer cannot accept are dropped and flagged.
- Reset or clr mid-sequence: takes effect at that edge. The stored data is abandoned but remains in the array; top_data=0 because empty.

## Test plan
- Reset, then idle -> count=0, empty=1, full=0, pop_valid=0, pop_data=0, top_data=0, no error flags.
- Defaults (DEPTH=8). Push 0x11..0x18 on 8 consecutive cycles:
  - count goes 1..8; almost_full=1 from count=7; full=1 at count=8
  - top_data=0x18
  - 9th push of 0x99 -> dropped, count=8, overflow=1
- From full, pop 8 cycles -> pop_data 0x18,0x17,...,0x11, each with pop_valid one cycle later. Then empty=1, almost_empty=1 from count=1. An extra pop -> underflow=1, pop_valid=0, pop_data stays 0x11.
- Push 0x01, 0x02, then push 0x03 with pop in the same cycle -> pop_data=0x02, count=2, top_data=0x03. Then pop twice -> 0x03, 0x01.
- While empty, push 0x5A with pop in the same cycle -> next cycle pop_data=0x5A, pop_valid=1, count=0, no flags.
- Push 3 words with overflow=1 set, then assert clr together with push -> count=0, overflow=0, push ignored. Repeat with rst asserted mid-burst -> all reset values restored.

Source files
------------

// File: rtl/lifo_buffer_if.sv
// Push/pop/status bundle for lifo_buffer. The master drives the requests
// and the slave (the stack) returns data and status.
interface lifo_buffer_if #(
    parameter int WORD_BITS = 8,
    parameter int ADRS_BITS = 3
);
  logic                 clr;
  logic                 push;
  logic [WORD_BITS-1:0] push_data;
  logic                 pop;
  logic [WORD_BITS-1:0] pop_data;
  logic                 pop_valid;
  logic [WORD_BITS-1:0] top_data;
  logic [ADRS_BITS:0]   count;
  logic                 empty;
  logic                 full;
  logic                 almost_empty;
  logic                 almost_full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output clr, push, push_data, pop,
    input  pop_data, pop_valid, top_data, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  clr, push, push_data, pop,
    output pop_data, pop_valid, top_data, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/lifo_buffer.sv
// Parametrised stack with exact count, threshold flags, registered pop output,
// combinational top-of-stack peek and sticky overflow/underflow errors.
module lifo_buffer #(
    parameter int WORD_BITS = 8,
    parameter int ADRS_BITS = 3,
    parameter int AF_LEVEL  = (2 ** ADRS_BITS) - 1,
    parameter int AE_LEVEL  = 1
) (
    input logic            clk,
    input logic            rst,
    lifo_buffer_if.slave   bus
);
  localparam int DEPTH = 2 ** ADRS_BITS;
  localparam int CNT_W = ADRS_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(AE_LEVEL);

  logic [WORD_BITS-1:0] mem [DEPTH];

  logic [CNT_W-1:0]     count_reg;
  logic [WORD_BITS-1:0] pop_data_reg;
  logic                 pop_valid_reg;
  logic                 overflow_reg;
  logic                 underflow_reg;

  logic                 is_empty;
  logic                 is_full;
  logic [ADRS_BITS-1:0] top_idx;
  logic                 wr_en;
  logic [ADRS_BITS-1:0] wr_addr;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CNT_DEPTH);
  // Low bits of count minus one wrap to DEPTH-1 when the stack is full.
  assign top_idx  = count_reg[ADRS_BITS-1:0] - ADRS_BITS'(1);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = count_reg[ADRS_BITS-1:0];
    if (!rst && !bus.clr && bus.push) begin
      if (bus.pop) begin
        wr_en   = !is_empty;
        wr_addr = top_idx;
      end else begin
        wr_en   = !is_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clr) begin
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pop_valid_reg <= 1'b0;
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (is_full) overflow_reg <= 1'b1;
          else         count_reg    <= count_reg + CNT_ONE;
        end
        2'b01: begin
          if (is_empty) begin
            underflow_reg <= 1'b1;
          end else begin
            pop_data_reg  <= mem[top_idx];
            pop_valid_reg <= 1'b1;
            count_reg     <= count_reg - CNT_ONE;
          end
        end
        2'b11: begin
          // Empty stack bypasses the pushed word straight to the output.
          pop_data_reg  <= is_empty ? bus.push_data : mem[top_idx];
          pop_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pop_data     = pop_data_reg;
  assign bus.pop_valid    = pop_valid_reg;
  assign bus.top_data     = is_empty ? '0 : mem[top_idx];
  assign bus.count        = count_reg;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (count_reg <= CNT_AE);
  assign bus.almost_full  = (count_reg >= CNT_AF);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule
